reg_dump_reader: RTL and testbench

// - Debug-side reader for the CPU register file: drives its debug read address (outaddr), samples its read data (reg_data).
// - On a start pulse, sweeps an address range and emits each register as one {addr,data} beat on a valid/ready stream.
// - Stream feeds the display/serial debug path.
// - Sits beside the register file; never touches the write port, so the CPU may keep running during a dump.

---
 rtl/reg_dump_reader.sv | 149 ++++++++++++++
 tb/tb_reg_dump_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Debug-side register file dumper: sweeps a wrapping address range and streams {addr,data} beats.
// Optional REG_DUMP_CKSUM_EN appends one XOR-checksum beat (out_addr=0) after the last register.
module reg_dump_reader #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] outaddr,
  input  logic [DW-1:0] reg_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | outaddr driven, counting down the read latency
  // SEND  | register beat offered on the stream
  // CSUM  | checksum beat offered (REG_DUMP_CKSUM_EN only)
  // DONE  | one-cycle done pulse
`ifdef REG_DUMP_CKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  // One extra cycle lets the registered outaddr settle before the latency count starts.
  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] end_q, end_d;
  logic [2:0]    wait_q, wait_d;
  logic [AW-1:0] outaddr_q, outaddr_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
`ifdef REG_DUMP_CKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      wait_q     <= '0;
      outaddr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
`ifdef REG_DUMP_CKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      wait_q     <= wait_d;
      outaddr_q  <= outaddr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
`ifdef REG_DUMP_CKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    wait_d     = wait_q;
    outaddr_d  = outaddr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
`ifdef REG_DUMP_CKSUM_EN
    acc_d      = acc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          wait_d  = WAIT_LOAD;
          state_d = S_READ;
`ifdef REG_DUMP_CKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_READ: begin
        outaddr_d = cur_q;
        if (wait_q == '0) begin
          out_data_d = reg_data;
          out_addr_d = cur_q;
          state_d    = S_SEND;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
`ifdef REG_DUMP_CKSUM_EN
          acc_d = acc_q ^ out_data_q;
`endif
          if (cur_q == end_q) begin
`ifdef REG_DUMP_CKSUM_EN
            out_addr_d = '0;
            out_data_d = acc_q ^ out_data_q;
            state_d    = S_CSUM;
`else
            state_d    = S_DONE;
`endif
          end else begin
            cur_d   = cur_q + 1'b1;
            wait_d  = WAIT_LOAD;
            state_d = S_READ;
          end
        end
      end
`ifdef REG_DUMP_CKSUM_EN
      S_CSUM: begin
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef REG_DUMP_CKSUM_EN
  assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
  assign out_valid = (state_q == S_SEND);
`endif
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign outaddr  = outaddr_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed vector table, reset abort, and random sweeps
// checked against an address-list model of the dump (honours REG_DUMP_CKSUM_EN).
module tb_reg_dump_reader;
  localparam int RD_LAT = 0;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr, last_addr;
  logic [4:0]  outaddr;
  logic [31:0] reg_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy, done;

  logic [31:0] regs [32];
  int n_cmp = 0;
  int n_fail = 0;

  assign reg_data = regs[outaddr];

  always #5 clk = ~clk;

  reg_dump_reader #(.AW(5), .DW(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .outaddr(outaddr), .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         mode;     // 0: ready high, 1: random ready, 2: 10-cycle stall on beat 2
    bit         restart;  // pulse start again mid-dump
    int         beats;    // register beats expected
  } vec_t;

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit restart, input int exp_beats, input string tag);
    logic [4:0]  ea[$];
    logic [31:0] ed[$];
    logic [4:0]  a;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic [31:0] x;
    int n, cyc, beats, stall, first_valid, want;
    bit expect_done, finished, prev_stall;
    n = ((int'(l) - int'(f)) & 31) + 1;
    x = 0;
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(f) + i) % 32);
      ea.push_back(a);
      ed.push_back(regs[a]);
      x ^= regs[a];
    end
    want = exp_beats;
`ifdef REG_DUMP_CKSUM_EN
    ea.push_back(5'd0);
    ed.push_back(x);
    want++;
`endif
    @(negedge clk);
    first_addr = f; last_addr = l; start = 1; out_ready = 0;
    @(negedge clk);
    start = 0;
    first_addr = 5'($urandom); last_addr = 5'($urandom);
    cyc = 1; beats = 0; stall = 0; first_valid = -1;
    expect_done = 0; finished = 0; prev_stall = 0; pa = 0; pd = 0;
    while (!finished && cyc < 3000) begin
      start = restart && (cyc == 5);
      if (expect_done) begin
        chk({tag, "_done_pulse"}, 64'(done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        out_ready = 0;
        @(negedge clk);
        chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        finished = 1;
      end else begin
        if (done) chk({tag, "_early_done"}, 64'(done), 64'd0);
        if (out_valid && first_valid < 0) begin
          first_valid = cyc;
          chk({tag, "_first_latency"}, 64'(cyc - 1), 64'(RD_LAT + 2));
        end
        if (prev_stall) begin
          chk({tag, "_valid_held"}, 64'(out_valid), 64'd1);
          chk({tag, "_addr_held"}, 64'(out_addr), 64'(pa));
          chk({tag, "_data_held"}, 64'(out_data), 64'(pd));
        end
        if (mode == 0) out_ready = 1;
        else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (out_valid && beats == 1 && stall < 10) begin
          out_ready = 0; stall++;
        end else out_ready = 1;
        if (out_valid && out_ready) begin
          if (ea.size() == 0) chk({tag, "_extra_beat"}, 64'(out_valid), 64'd0);
          else begin
            chk({tag, "_addr"}, 64'(out_addr), 64'(ea[0]));
            chk({tag, "_data"}, 64'(out_data), 64'(ed[0]));
            void'(ea.pop_front());
            void'(ed.pop_front());
            beats++;
            if (ea.size() == 0) expect_done = 1;
          end
        end
        prev_stall = out_valid && !out_ready;
        pa = out_addr; pd = out_data;
        @(negedge clk);
        cyc++;
      end
    end
    start = 0; out_ready = 0;
    if (!finished) chk({tag, "_timeout"}, 64'd0, 64'd1);
    chk({tag, "_beat_count"}, 64'(beats), 64'(want));
  endtask

  vec_t vecs[8];

  initial begin
    rst_n = 0; start = 0; out_ready = 0; first_addr = 0; last_addr = 0;
    foreach (regs[i]) regs[i] = 0;
    regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33; regs[4] = 32'h44;

    vecs[0] = '{f: 5'd1,  l: 5'd4,  mode: 0, restart: 0, beats: 4};
    vecs[1] = '{f: 5'd30, l: 5'd1,  mode: 0, restart: 0, beats: 4};
    vecs[2] = '{f: 5'd1,  l: 5'd4,  mode: 2, restart: 0, beats: 4};
    vecs[3] = '{f: 5'd1,  l: 5'd4,  mode: 0, restart: 1, beats: 4};
    vecs[4] = '{f: 5'd5,  l: 5'd5,  mode: 0, restart: 0, beats: 1};
    vecs[5] = '{f: 5'd0,  l: 5'd31, mode: 0, restart: 0, beats: 32};
    vecs[6] = '{f: 5'd31, l: 5'd0,  mode: 1, restart: 0, beats: 2};
    vecs[7] = '{f: 5'd10, l: 5'd3,  mode: 1, restart: 0, beats: 26};

    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({outaddr, out_valid, out_addr, out_data, busy, done}), 64'd0);
    rst_n = 1;

    for (int v = 0; v < 8; v++)
      run_dump(vecs[v].f, vecs[v].l, vecs[v].mode, vecs[v].restart, vecs[v].beats,
               $sformatf("vec%0d", v));

    // Abort in the middle of beat 3, then prove a fresh dump still runs cleanly.
    regs[5] = 32'h55; regs[6] = 32'h66;
    @(negedge clk);
    first_addr = 1; last_addr = 6; start = 1; out_ready = 1;
    @(negedge clk);
    start = 0;
    begin
      bit found;
      found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
        if (out_valid && out_addr == 5'd3) found = 1;
        else @(negedge clk);
      end
      chk("rst_reach_beat3", 64'(found), 64'd1);
    end
    out_ready = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_outputs", 64'({outaddr, out_valid, out_addr, out_data, busy, done}), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_done", 64'({done, busy}), 64'd0);
    end
    rst_n = 1;
    run_dump(5'd1, 5'd4, 0, 0, 4, "post_reset");

    for (int r = 0; r < 20; r++) begin
      logic [4:0] f, l;
      foreach (regs[i]) regs[i] = $urandom;
      f = 5'($urandom); l = 5'($urandom);
      run_dump(f, l, 1, r[0], ((int'(l) - int'(f)) & 31) + 1, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
